hanoivm_core_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one hanoivm_fsm opcode interpreter core between N_REQ requesters (VM threads / host ports).
- Accepts one opcode+operand per requester transaction and drives the core's valid/ready handshake.
- Waits for the core's done pulse and returns the T81 result to the owning requester.
- A watchdog recovers from a core that never completes.

---
 rtl/hanoivm_arb_pkg.sv | 19 +
 rtl/hanoivm_rr_pick.sv | 38 +++
 rtl/hanoivm_core_arbiter.sv | 145 ++++++++++++++
 tb/tb_hanoivm_core_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hanoivm_arb_pkg.sv
// rtl/hanoivm_arb_pkg.sv - shared types and opcode constants for the hanoivm core arbiter
package hanoivm_arb_pkg;

    localparam int OPW_DEF = 8;
    localparam int DW_DEF  = 81;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_PUSH = 8'h01;
    localparam logic [7:0] OP_POP  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h03;

endpackage

// File: rtl/hanoivm_rr_pick.sv
// rtl/hanoivm_rr_pick.sv - combinational rotate-priority picker
// Scans req starting at ptr and wrapping; reports the first set bit as one-hot and index.
module hanoivm_rr_pick #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   slot_sum;
    logic [IW-1:0] slot;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        slot_sum = '0;
        slot     = '0;
        for (int k = 0; k < N; k++) begin
            // one extra bit keeps ptr+k exact before the modulo fold
            slot_sum = {1'b0, ptr} + (IW+1)'(k);
            if (slot_sum >= (IW+1)'(N)) begin
                slot_sum = slot_sum - (IW+1)'(N);
            end
            slot = slot_sum[IW-1:0];
            if (!any && req[slot]) begin
                any         = 1'b1;
                grant[slot] = 1'b1;
                idx         = slot;
            end
        end
    end

endmodule

// File: rtl/hanoivm_core_arbiter.sv
// rtl/hanoivm_core_arbiter.sv - round-robin sequencer sharing one hanoivm_fsm core among requesters
// One transaction in flight: accept, issue, wait for done (or watchdog), respond to owner.
module hanoivm_core_arbiter
    import hanoivm_arb_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  OPW     = OPW_DEF,
    parameter int  DW      = DW_DEF,
    parameter int  TIMEOUT = 64,
    localparam int IW      = $clog2(N_REQ),
    localparam int CW      = $clog2(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*OPW-1:0] req_opcode,
    input  logic [N_REQ*DW-1:0]  req_operand,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_error,
    output logic                 core_valid,
    output logic [OPW-1:0]       core_opcode,
    output logic [DW-1:0]        core_operand,
    input  logic                 core_ready,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_result,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [IW-1:0]  rr_ptr;
    logic [CW-1:0]  wd_cnt;
    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic           accept;
    logic           timeout_hit;
    logic [OPW-1:0] sel_opcode;
    logic [DW-1:0]  sel_operand;
    logic [N_REQ-1:0] owner_onehot;
    logic [IW-1:0]  rr_next;

    hanoivm_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // rst gate keeps req_ready low while the arbiter is held in reset
    assign accept       = (state_q == ARB) && core_ready && pick_any && !rst;
    assign timeout_hit  = (wd_cnt == CW'(TIMEOUT - 1));
    assign owner_onehot = N_REQ'(1) << grant_id;
    assign rr_next      = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
    assign busy         = (state_q != ARB);

    always_comb begin
        sel_opcode  = '0;
        sel_operand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_opcode  = req_opcode[i*OPW +: OPW];
                sel_operand = req_operand[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            ARB: begin
                if (accept) begin
                    req_ready = pick_grant;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (core_done || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            wd_cnt       <= '0;
            grant_id     <= '0;
            core_valid   <= 1'b0;
            core_opcode  <= '0;
            core_operand <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
        end else begin
            core_valid <= accept;
            rsp_valid  <= '0;
            case (state_q)
                ARB: begin
                    if (accept) begin
                        core_opcode  <= sel_opcode;
                        core_operand <= sel_operand;
                        grant_id     <= pick_idx;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    wd_cnt <= wd_cnt + CW'(1);
                    // done beats the watchdog when both land in the same cycle
                    if (core_done) begin
                        rsp_data  <= core_result;
                        rsp_error <= 1'b0;
                        rsp_valid <= owner_onehot;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        rsp_error <= 1'b1;
                        rsp_valid <= owner_onehot;
                    end
                end
                RESP: rr_ptr <= rr_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hanoivm_core_arbiter.sv
// tb/tb_hanoivm_core_arbiter.sv - self-checking bench for hanoivm_core_arbiter
module tb_hanoivm_core_arbiter;
    import hanoivm_arb_pkg::*;

    localparam int N   = 4;
    localparam int OPW = 8;
    localparam int DW  = 81;
    localparam int TO  = 16;
    localparam int IW  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N*OPW-1:0]   req_opcode = '0;
    logic [N*DW-1:0]    req_operand = '0;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               rsp_error;
    logic               core_valid;
    logic [OPW-1:0]     core_opcode;
    logic [DW-1:0]      core_operand;
    logic               core_ready = 1'b1;
    logic               core_done;
    logic [DW-1:0]      core_result;
    logic               busy;
    logic [IW-1:0]      grant_id;

    hanoivm_core_arbiter #(
        .N_REQ   (N),
        .OPW     (OPW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_opcode   (req_opcode),
        .req_operand  (req_operand),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .core_valid   (core_valid),
        .core_opcode  (core_opcode),
        .core_operand (core_operand),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .core_result  (core_result),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    // core stand-in: stack machine, done four cycles after the valid cycle
    logic [DW-1:0] core_stack [$];
    logic [DW-1:0] cm_res = '0;
    logic          cm_done = 1'b0;
    int            cm_cnt = 0;
    logic          stall = 1'b0;
    logic          inj_done = 1'b0;

    assign core_done   = cm_done | inj_done;
    assign core_result = cm_res;

    function automatic logic [DW-1:0] core_exec(input logic [OPW-1:0] op, input logic [DW-1:0] opd);
        logic [DW-1:0] a, b;
        case (op)
            OP_PUSH: begin core_stack.push_back(opd); return opd; end
            OP_POP:  return (core_stack.size() != 0) ? core_stack.pop_back() : '0;
            OP_ADD: begin
                a = (core_stack.size() != 0) ? core_stack.pop_back() : '0;
                b = (core_stack.size() != 0) ? core_stack.pop_back() : '0;
                core_stack.push_back(a + b);
                return a + b;
            end
            default: return ~opd;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_cnt  <= 0;
            cm_done <= 1'b0;
            cm_res  <= '0;
            core_stack.delete();
        end else begin
            cm_done <= 1'b0;
            if (core_valid && !stall) begin
                cm_cnt <= 3;
                cm_res <= core_exec(core_opcode, core_operand);
            end else if (cm_cnt != 0) begin
                cm_cnt <= cm_cnt - 1;
                if (cm_cnt == 1) cm_done <= 1'b1;
            end
        end
    end

    // reference model: one transaction record with its predicted timeline
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [N-1:0]  pend = '0;
    logic [OPW-1:0] p_op [N];
    logic [DW-1:0] p_opd [N];
    logic [DW-1:0] ref_stack [$];
    logic          m_active = 1'b0;
    int            m_acc = 0, m_rsp = 0, m_gid = 0, m_rr = 0;
    logic [OPW-1:0] m_op = '0;
    logic [DW-1:0] m_opd = '0, m_rd = '0;
    logic          m_re = 1'b0;
    int            dut_acc [$];
    int            dut_acc_cyc [$];
    logic [DW-1:0] last_rsp_data = '0;
    logic          last_rsp_err = 1'b0;
    logic [N-1:0]  last_owner = '0;
    int            last_rsp_cyc = 0;

    function automatic logic [DW-1:0] ref_exec(input logic [OPW-1:0] op, input logic [DW-1:0] opd);
        logic [DW-1:0] top0, top1;
        top0 = (ref_stack.size() > 0) ? ref_stack[ref_stack.size()-1] : '0;
        top1 = (ref_stack.size() > 1) ? ref_stack[ref_stack.size()-2] : '0;
        if (op == OP_PUSH) begin
            ref_stack.push_back(opd);
            return opd;
        end
        if (op == OP_POP) begin
            if (ref_stack.size() > 0) ref_stack.delete(ref_stack.size()-1);
            return top0;
        end
        if (op == OP_ADD) begin
            repeat (2) if (ref_stack.size() > 0) ref_stack.delete(ref_stack.size()-1);
            ref_stack.push_back(top0 + top1);
            return top0 + top1;
        end
        return ~opd;
    endfunction

    function automatic logic [DW-1:0] rand81();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy, exp_rv;
        int w;
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_opcode[i*OPW +: OPW] = p_op[i];
            req_operand[i*DW +: DW]  = p_opd[i];
        end
        if (m_active && cyc > m_rsp) m_active = 1'b0;
        exp_rdy = '0;
        w = -1;
        if (!rst && !m_active && core_ready && pend != '0) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pend[(m_rr + k) % N]) w = (m_rr + k) % N;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        exp_rv = (m_active && cyc == m_rsp) ? (N'(1) << m_gid) : '0;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        chk("core_valid", core_valid, m_active && cyc == m_acc + 1);
        chk("core_opcode", core_opcode, m_op);
        chk("core_operand", core_operand, m_opd);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != '0) begin
            chk("rsp_data", rsp_data, m_rd);
            chk("rsp_error", rsp_error, m_re);
        end
        chk("busy", busy, m_active && cyc > m_acc);
        chk("grant_id", grant_id, m_gid);
        if (rsp_valid != '0) begin
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_error;
            last_owner    = rsp_valid;
            last_rsp_cyc  = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                dut_acc.push_back(i);
                dut_acc_cyc.push_back(cyc);
            end
        end
        if (w >= 0) begin
            m_active = 1'b1;
            m_acc    = cyc;
            m_gid    = w;
            m_op     = p_op[w];
            m_opd    = p_opd[w];
            m_rr     = (w + 1) % N;
            if (stall) begin
                m_rsp = cyc + 2 + TO;
                m_rd  = '0;
                m_re  = 1'b1;
            end else begin
                m_rsp = cyc + 6;
                m_rd  = ref_exec(m_op, m_opd);
                m_re  = 1'b0;
            end
            pend[w] = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((m_active || pend != '0) && n < limit) begin
            step();
            n++;
        end
        chk("idle_within_bound", (m_active || pend != '0), 1'b0);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_error", rsp_error, '0);
        chk("rst_core_valid", core_valid, '0);
        chk("rst_core_opcode", core_opcode, '0);
        chk("rst_core_operand", core_operand, '0);
        chk("rst_busy", busy, '0);
        chk("rst_grant_id", grant_id, '0);
        m_active = 1'b0;
        m_rr     = 0;
        m_gid    = 0;
        m_op     = '0;
        m_opd    = '0;
        ref_stack.delete();
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0;
    endtask

    task automatic send(input int r, input logic [OPW-1:0] op, input logic [DW-1:0] opd);
        pend[r]  = 1'b1;
        p_op[r]  = op;
        p_opd[r] = opd;
    endtask

    initial begin
        int n0, guard;
        int order [5];
        logic [DW-1:0] stack_exp [4];
        order = '{0, 1, 2, 3, 0};
        stack_exp = '{81'd3, 81'd4, 81'd7, 81'd7};
        for (int i = 0; i < N; i++) begin
            p_op[i]  = '0;
            p_opd[i] = '0;
        end

        #2;
        apply_reset(2);

        // contention: all requesters keep asking, order from rr_ptr=0
        n0 = dut_acc.size();
        for (int i = 0; i < N; i++) send(i, OP_NOP, rand81());
        guard = 0;
        while (dut_acc.size() < n0 + 5 && guard < 100) begin
            step();
            guard++;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && dut_acc.size() < n0 + 5) send(i, OP_NOP, rand81());
            end
        end
        wait_idle(200);
        chk("cont_accepts", dut_acc.size() >= n0 + 5, 1'b1);
        if (dut_acc.size() >= n0 + 5) begin
            for (int k = 0; k < 5; k++) chk("cont_order", dut_acc[n0 + k], order[k]);
            for (int k = 0; k < 4; k++)
                chk("cont_spacing", dut_acc_cyc[n0 + k + 1] - dut_acc_cyc[n0 + k], 7);
        end

        // single requester, latency
        send(0, OP_PUSH, 81'd5);
        wait_idle(40);
        chk("single_data", last_rsp_data, 81'd5);
        chk("single_err", last_rsp_err, 1'b0);
        chk("single_owner", last_owner, 4'b0001);
        chk("single_latency", last_rsp_cyc - dut_acc_cyc[dut_acc.size()-1], 6);

        // stack operations through the arbiter
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: send(1, OP_PUSH, 81'd3);
                1: send(2, OP_PUSH, 81'd4);
                2: send(1, OP_ADD, 81'd0);
                default: send(0, OP_POP, 81'd0);
            endcase
            wait_idle(40);
            chk("stack_data", last_rsp_data, stack_exp[k]);
        end

        // stalled core: watchdog response, then a stale done
        stall = 1'b1;
        send(3, OP_NOP, rand81());
        wait_idle(TO + 20);
        chk("timeout_err", last_rsp_err, 1'b1);
        chk("timeout_data", last_rsp_data, '0);
        chk("timeout_owner", last_owner, 4'b1000);
        chk("timeout_latency", last_rsp_cyc - dut_acc_cyc[dut_acc.size()-1], TO + 2);
        stall = 1'b0;
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        repeat (3) step();

        // core not ready: request waits, accepted the cycle ready rises
        core_ready = 1'b0;
        send(1, OP_NOP, rand81());
        n0 = dut_acc.size();
        repeat (4) step();
        chk("held_no_accept", dut_acc.size(), n0);
        core_ready = 1'b1;
        step();
        chk("accept_on_ready", dut_acc.size(), n0 + 1);
        wait_idle(40);

        // reset during WAIT abandons the transaction and clears rr_ptr
        send(1, OP_NOP, rand81());
        guard = 0;
        while (!(m_active && cyc == m_acc + 3) && guard < 40) begin
            step();
            guard++;
        end
        chk("reached_wait", m_active && cyc == m_acc + 3, 1'b1);
        apply_reset(2);
        repeat (8) step();
        n0 = dut_acc.size();
        send(1, OP_NOP, rand81());
        send(3, OP_NOP, rand81());
        wait_idle(60);
        chk("post_rst_first", dut_acc[n0], 1);
        n0 = dut_acc.size();
        send(2, OP_NOP, rand81());
        wait_idle(40);
        chk("post_rst_req2", dut_acc[n0], 2);

        // randomized traffic against the reference timeline
        for (int c = 0; c < 400; c++) begin
            core_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    send(i, OPW'($urandom_range(0, 3)), rand81());
            end
            step();
        end
        core_ready = 1'b1;
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
